// File: rtl/serial_pair_pkg.sv
// rtl/serial_pair_pkg.sv - shared types, defaults and sizing helper for serial_pair_tx
package serial_pair_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_GAP_CYC = 2;

    // Bits needed to hold any value 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_pair_shreg.sv
// rtl/serial_pair_shreg.sv - loadable right-shift register with hold, LSB presented as the serial bit
module serial_pair_shreg #(
    parameter int W = 8
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    output logic         lsb
);

    logic [W-1:0] q;

    // Zeros shift in at the top so the line idles low once the word is spent.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {1'b0, q[W-1:1]};
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/serial_pair_tx.sv
// rtl/serial_pair_tx.sv - two-line LSB-first serial transmitter with hold and inter-frame gap; SERIAL_PAIR_PARITY_EN adds an even-parity slot
module serial_pair_tx
    import serial_pair_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HOLD,
    output logic             LINE1,
    output logic             LINE2,
    output logic             FRAME,
    output logic             DONE,
    output logic             BUSY
);

`ifdef SERIAL_PAIR_PARITY_EN
    localparam int SLOTS = WIDTH + 1;
`else
    localparam int SLOTS = WIDTH;
`endif
    localparam int CW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYC);
    localparam logic [CW-1:0] LAST  = CW'(SLOTS - 1);
    localparam logic [GW-1:0] GLAST = GW'(GAP_CYC - 1);

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [GW-1:0]   gcnt, gcnt_d;
    logic            done_d;
    logic            accept, advance;
    logic [SLOTS-1:0] a_word, b_word;

`ifdef SERIAL_PAIR_PARITY_EN
    // Parity rides as the top slot so it falls out of the shifter after the data.
    assign a_word = {^A, A};
    assign b_word = {^B, B};
`else
    assign a_word = A;
    assign b_word = B;
`endif

    assign accept   = (state == IDLE) && IN_VALID;
    assign advance  = (state == SHIFT) && !HOLD;
    assign IN_READY = (state == IDLE);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            cnt   <= '0;
            gcnt  <= '0;
            FRAME <= 1'b0;
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            gcnt  <= gcnt_d;
            FRAME <= (state_d == SHIFT);
            DONE  <= done_d;
            BUSY  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        gcnt_d  = gcnt;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (IN_VALID) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (!HOLD) begin
                    if (cnt == LAST) begin
                        state_d = GAP;
                        gcnt_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            GAP: begin
                if (gcnt == GLAST) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    serial_pair_shreg #(.W(SLOTS)) u_shreg_a (
        .CK    (CK),
        .RN    (RN),
        .load  (accept),
        .din   (a_word),
        .shift (advance),
        .lsb   (LINE1)
    );

    serial_pair_shreg #(.W(SLOTS)) u_shreg_b (
        .CK    (CK),
        .RN    (RN),
        .load  (accept),
        .din   (b_word),
        .shift (advance),
        .lsb   (LINE2)
    );

endmodule

// File: tb/tb_serial_pair_tx.sv
// tb/tb_serial_pair_tx.sv - directed table-driven bench for serial_pair_tx
module tb_serial_pair_tx;

    localparam int W = 8;
`ifdef SERIAL_PAIR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         CK = 1'b0;
    logic         RN = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         HOLD = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         IN_READY, LINE1, LINE2, FRAME, DONE, BUSY;
    logic [5:0]   outs;

    assign outs = {LINE1, LINE2, FRAME, DONE, BUSY, IN_READY};

    always #5 CK = ~CK;

    serial_pair_tx #(.WIDTH(W), .GAP_CYC(2)) dut (
        .CK       (CK),
        .RN       (RN),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .HOLD     (HOLD),
        .LINE1    (LINE1),
        .LINE2    (LINE2),
        .FRAME    (FRAME),
        .DONE     (DONE),
        .BUSY     (BUSY)
    );

    // exp_done / exp_ready are cycle offsets after the accept edge for the no-parity build.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         hold_at;
        int         hold_len;
        int         exp_done;
        int         exp_ready;
    } vec_t;

    vec_t vecs[5];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b (L1 L2 FRAME DONE BUSY RDY)", name, act, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (IN_READY !== 1'b1 && n < 50) begin
            @(negedge CK);
            n++;
        end
        if (IN_READY !== 1'b1) begin
            total++;
            $display("FAIL wait_ready: IN_READY=%b after %0d cycles, expected 1", IN_READY, n);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int         k;
        int         done_c;
        int         ready_c;
        logic       l1, l2;
        logic [5:0] exp;
        k       = 0;
        done_c  = v.exp_done + PAR;
        ready_c = v.exp_ready + PAR;
        wait_ready();
        A        = v.a;
        B        = v.b;
        IN_VALID = 1'b1;
        @(negedge CK);
        IN_VALID = 1'b0;
        for (int c = 1; c <= ready_c; c++) begin
            HOLD = (v.hold_at >= 0) && (c >= 1 + v.hold_at) && (c < 1 + v.hold_at + v.hold_len);
            l1 = 1'b0;
            l2 = 1'b0;
            if (c < done_c) begin
                l1 = (k < W) ? v.a[k] : ^v.a;
                l2 = (k < W) ? v.b[k] : ^v.b;
            end
            exp = {l1, l2, c < done_c, c == done_c, c < ready_c, c == ready_c};
            check($sformatf("%s c%0d", tag, c), outs, exp);
            if (!HOLD) k++;
            @(negedge CK);
        end
        HOLD = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h3D, -1, 0,  9, 11};
        vecs[1] = '{8'hA5, 8'h3D,  3, 3, 12, 14};
        vecs[2] = '{8'hFF, 8'h00, -1, 0,  9, 11};
        vecs[3] = '{8'h01, 8'h80,  0, 2, 11, 13};
        vecs[4] = '{8'h00, 8'hFF,  7, 1, 10, 12};

        repeat (2) @(negedge CK);
        check("reset_outs", {outs[5:1], 1'b0}, 6'b000000);
        RN = 1'b1;
        @(negedge CK);
        check("ready_after_reset", outs, 6'b000001);

        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: IN_VALID stays high, second pair lands exactly when IDLE returns.
        wait_ready();
        A = 8'hA5; B = 8'h3D; IN_VALID = 1'b1;
        @(negedge CK);
        A = 8'hFF; B = 8'h00;
        check("b2b_bit0", outs, 6'b111010);
        @(negedge CK);
        check("b2b_ignore_bit1", outs, 6'b001010);
        repeat (9 + PAR) @(negedge CK);
        check("b2b_ready", outs, 6'b000001);
        @(negedge CK);
        IN_VALID = 1'b0;
        check("b2b_second_bit0", outs, 6'b101010);
        @(negedge CK);
        check("b2b_second_bit1", outs, 6'b101010);

        // Abort at bit 4: asynchronous clear, no DONE, then a clean frame.
        wait_ready();
        A = 8'hA5; B = 8'h3D; IN_VALID = 1'b1;
        @(negedge CK);
        IN_VALID = 1'b0;
        repeat (4) @(negedge CK);
        check("pre_abort_bit4", outs, 6'b011010);
        #2 RN = 1'b0;
        #1 check("abort_async", {outs[5:1], 1'b0}, 6'b000000);
        @(negedge CK);
        RN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CK);
            check($sformatf("abort_idle%0d", i), outs, 6'b000001);
        end
        run_frame('{8'h3C, 8'hC3, -1, 0, 9, 11}, "post_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
